seg_scan_drv: RTL and testbench



---
 rtl/seg_scan_if.sv | 25 ++
 rtl/seg_scan_drv.sv | 126 ++++++++++++
 tb/tb_seg_scan_drv.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Display-side bundle between the BCD source / board pins and the segment scanner.
// The master side drives the digits and controls; the slave side is the scanner.
interface seg_scan_if;
    logic       en;
    logic [3:0] one;
    logic [3:0] ten;
    logic [3:0] hun;
    logic [3:0] tho;
    logic [3:0] dp_en;
    logic       lzb;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       frame_tick;

    modport master (
        output en, one, ten, hun, tho, dp_en, lzb,
        input  seg, dp, dig, frame_tick
    );

    modport slave (
        input  en, one, ten, hun, tho, dp_en, lzb,
        output seg, dp, dig, frame_tick
    );
endinterface

// File: rtl/seg_scan_drv.sv
// Time-multiplexed 4-digit 7-segment driver: per-frame snapshot of BCD digits,
// programmable slot rate, dead-time between digits and leading-zero blanking.
module seg_scan_drv #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    localparam int unsigned      CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0]       DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    // Active-high {g..a}; non-BCD codes render as a minus sign
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   sh_dig_q, sh_dig_d;
    logic [3:0]        sh_dp_q, sh_dp_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        dig_q, dig_d;
    logic              ft_q, ft_d;

    logic              tick;
    logic              frame_end;
    logic [3:0]        blank;
    logic [6:0]        lit;
    logic [3:0]        dig_on;

    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_dig_d  = sh_dig_q;
        sh_dp_d   = sh_dp_q;
        tick      = (cnt_q == CNT_MAX);
        frame_end = tick && (idx_q == 2'd3);
        ft_d      = bus.en && frame_end;

        // Disable dominates any coincident tick
        if (!bus.en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!bus.en || frame_end) begin
            sh_dig_d = {bus.tho, bus.hun, bus.ten, bus.one};
            sh_dp_d  = bus.dp_en;
        end

        // A digit blanks only when it and every higher digit are zero
        blank[3] = (sh_dig_q[3] == 4'd0);
        blank[2] = blank[3] && (sh_dig_q[2] == 4'd0);
        blank[1] = blank[2] && (sh_dig_q[1] == 4'd0);
        blank[0] = 1'b0;

        lit    = (bus.lzb && blank[idx_q]) ? 7'h00 : bcd_to_seg(sh_dig_q[idx_q]);
        dig_on = (32'(cnt_q) < BLANK_CYC) ? 4'h0 : (4'b0001 << idx_q);

        seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
        dp_d  = sh_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
        dig_d = DIG_ACTIVE_LOW ? ~dig_on : dig_on;

        if (!bus.en) begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
            dig_d = DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_dig_q <= '0;
            sh_dp_q  <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            dig_q    <= DIG_OFF;
            ft_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            dig_q    <= dig_d;
            ft_q     <= ft_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.dig        = dig_q;
    assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with SCAN_DIV=8, BLANK_CYC=2, active-low pins.
module tb_seg_scan_drv;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan_drv #(
        .SCAN_DIV       (8),
        .BLANK_CYC      (2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] th, input logic [3:0] h,
                              input logic [3:0] t, input logic [3:0] o);
        bus.tho = th;
        bus.hun = h;
        bus.ten = t;
        bus.one = o;
    endtask

    // One disabled cycle loads the shadow, then scanning starts at slot 0, cnt 0
    task automatic restart();
        bus.en = 1'b0;
        step();
        bus.en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b1;
        repeat (3) step();
        if (bus.seg !== 7'h7F) begin $display("FAIL reset_seg got=%h want=7f", bus.seg); bad++; end
        total++;
        if (bus.dp !== 1'b1) begin $display("FAIL reset_dp got=%b want=1", bus.dp); bad++; end
        total++;
        if (bus.dig !== 4'hF) begin $display("FAIL reset_dig got=%h want=f", bus.dig); bad++; end
        total++;
        if (bus.frame_tick !== 1'b0) begin $display("FAIL reset_ft got=%b want=0", bus.frame_tick); bad++; end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_digit_scan();
        logic [6:0] es [4];
        logic [3:0] ed [4];
        es = '{7'h19, 7'h30, 7'h24, 7'h79};
        ed = '{4'hE, 4'hD, 4'hB, 4'h7};
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.dp_en = 4'b0000;
        bus.lzb   = 1'b0;
        restart();
        for (int k = 0; k < 64; k++) begin
            int s;
            logic [3:0] wd;
            logic wf;
            step();
            s  = (k / 8) % 4;
            wd = ((k % 8) < 2) ? 4'hF : ed[s];
            wf = ((k % 32) == 31);
            if (bus.dig !== wd) begin $display("FAIL scan_dig k=%0d got=%h want=%h", k, bus.dig, wd); bad++; end
            total++;
            if (bus.seg !== es[s]) begin $display("FAIL scan_seg k=%0d got=%h want=%h", k, bus.seg, es[s]); bad++; end
            total++;
            if (bus.dp !== 1'b1) begin $display("FAIL scan_dp k=%0d got=%b want=1", k, bus.dp); bad++; end
            total++;
            if (bus.frame_tick !== wf) begin $display("FAIL scan_ft k=%0d got=%b want=%b", k, bus.frame_tick, wf); bad++; end
            total++;
        end
    endtask

    task automatic test_lzb();
        logic [6:0] es_on  [4];
        logic [6:0] es_off [4];
        logic [3:0] ed [4];
        es_on  = '{7'h40, 7'h19, 7'h7F, 7'h7F};
        es_off = '{7'h40, 7'h19, 7'h40, 7'h40};
        ed     = '{4'hE, 4'hD, 4'hB, 4'h7};
        set_digits(4'd0, 4'd0, 4'd4, 4'd0);
        bus.dp_en = 4'b0000;
        bus.lzb   = 1'b1;
        restart();
        for (int k = 0; k < 32; k++) begin
            int s;
            logic [3:0] wd;
            step();
            s  = k / 8;
            wd = ((k % 8) < 2) ? 4'hF : ed[s];
            if (bus.seg !== es_on[s]) begin $display("FAIL lzb_on_seg k=%0d got=%h want=%h", k, bus.seg, es_on[s]); bad++; end
            total++;
            if (bus.dig !== wd) begin $display("FAIL lzb_on_dig k=%0d got=%h want=%h", k, bus.dig, wd); bad++; end
            total++;
        end
        bus.lzb = 1'b0;
        restart();
        for (int k = 0; k < 32; k++) begin
            int s;
            step();
            s = k / 8;
            if (bus.seg !== es_off[s]) begin $display("FAIL lzb_off_seg k=%0d got=%h want=%h", k, bus.seg, es_off[s]); bad++; end
            total++;
        end
    endtask

    task automatic test_tear_free();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.dp_en = 4'b0000;
        bus.lzb   = 1'b0;
        restart();
        for (int k = 0; k < 40; k++) begin
            logic [6:0] ws;
            logic wf;
            step();
            ws = (k < 32) ? 7'h19 : 7'h10;
            wf = (k == 31);
            if ((k % 32) < 8) begin
                if (bus.seg !== ws) begin $display("FAIL tear_seg k=%0d got=%h want=%h", k, bus.seg, ws); bad++; end
                total++;
            end
            if (bus.frame_tick !== wf) begin $display("FAIL tear_ft k=%0d got=%b want=%b", k, bus.frame_tick, wf); bad++; end
            total++;
            if (k == 3) bus.one = 4'd9;
        end
    endtask

    task automatic test_invalid_dp();
        logic [6:0] es [4];
        logic       ep [4];
        es = '{7'h3F, 7'h30, 7'h24, 7'h79};
        ep = '{1'b0, 1'b1, 1'b1, 1'b1};
        set_digits(4'd1, 4'd2, 4'd3, 4'hA);
        bus.dp_en = 4'b0001;
        bus.lzb   = 1'b0;
        restart();
        for (int k = 0; k < 32; k++) begin
            int s;
            step();
            s = k / 8;
            if (bus.seg !== es[s]) begin $display("FAIL inv_seg k=%0d got=%h want=%h", k, bus.seg, es[s]); bad++; end
            total++;
            if (bus.dp !== ep[s]) begin $display("FAIL inv_dp k=%0d got=%b want=%b", k, bus.dp, ep[s]); bad++; end
            total++;
        end
    endtask

    task automatic test_disable();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.dp_en = 4'b0000;
        bus.lzb   = 1'b0;
        restart();
        repeat (20) step();
        bus.en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (bus.dig !== 4'hF) begin $display("FAIL dis_dig k=%0d got=%h want=f", k, bus.dig); bad++; end
            total++;
            if (bus.seg !== 7'h7F) begin $display("FAIL dis_seg k=%0d got=%h want=7f", k, bus.seg); bad++; end
            total++;
            if (bus.dp !== 1'b1) begin $display("FAIL dis_dp k=%0d got=%b want=1", k, bus.dp); bad++; end
            total++;
        end
        bus.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] wd;
            step();
            wd = (k < 2) ? 4'hF : 4'hE;
            if (bus.dig !== wd) begin $display("FAIL reen_dig k=%0d got=%h want=%h", k, bus.dig, wd); bad++; end
            total++;
        end
        if (bus.seg !== 7'h19) begin $display("FAIL reen_seg got=%h want=19", bus.seg); bad++; end
        total++;
        // Drop en exactly on the frame-end tick: no frame_tick may follow
        repeat (28) step();
        bus.en = 1'b0;
        step();
        if (bus.frame_tick !== 1'b0) begin $display("FAIL dis_tick_ft got=%b want=0", bus.frame_tick); bad++; end
        total++;
        if (bus.dig !== 4'hF) begin $display("FAIL dis_tick_dig got=%h want=f", bus.dig); bad++; end
        total++;
        bus.en = 1'b1;
    endtask

    task automatic test_async_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.dp_en = 4'b0000;
        bus.lzb   = 1'b0;
        restart();
        repeat (5) step();
        if (bus.dig !== 4'hE) begin $display("FAIL pre_rst_dig got=%h want=e", bus.dig); bad++; end
        total++;
        #2;
        rst_n = 1'b0;
        #1;
        if (bus.dig !== 4'hF) begin $display("FAIL arst_dig got=%h want=f", bus.dig); bad++; end
        total++;
        if (bus.seg !== 7'h7F) begin $display("FAIL arst_seg got=%h want=7f", bus.seg); bad++; end
        total++;
        if (bus.dp !== 1'b1) begin $display("FAIL arst_dp got=%b want=1", bus.dp); bad++; end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        // Shadow was cleared, so slot 0 shows a zero once scanning resumes
        for (int k = 0; k < 3; k++) begin
            logic [3:0] wd;
            step();
            wd = (k < 2) ? 4'hF : 4'hE;
            if (bus.dig !== wd) begin $display("FAIL post_rst_dig k=%0d got=%h want=%h", k, bus.dig, wd); bad++; end
            total++;
        end
        if (bus.seg !== 7'h40) begin $display("FAIL post_rst_seg got=%h want=40", bus.seg); bad++; end
        total++;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.lzb   = 1'b0;
        bus.dp_en = 4'b0000;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_digit_scan();
        test_lzb();
        test_tear_free();
        test_invalid_dp();
        test_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
